// File: rtl/layer0_input_quantizer.sv
// Streams raw feature beats and turns each one into a 2-bit code by counting
// how many of three programmable per-feature thresholds it reaches. The packed
// vector is held until the layer0 side accepts it.
//
// state   | meaning
// IDLE    | waiting for the first beat of a vector (index 0)
// COLLECT | part of a vector has been received and quantized
// HOLD    | full vector presented on m_data, waiting for m_ready
// DRAIN   | overlong vector, dropping beats up to and including s_last
module layer0_input_quantizer #(
  parameter int                NUM_FEATURES = 3,
  parameter int                FEAT_W       = 8,
  parameter logic [FEAT_W-1:0] T0_INIT      = FEAT_W'(64),
  parameter logic [FEAT_W-1:0] T1_INIT      = FEAT_W'(128),
  parameter logic [FEAT_W-1:0] T2_INIT      = FEAT_W'(192),
  localparam int               IDX_W        = $clog2(NUM_FEATURES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [FEAT_W-1:0]         s_data,
  input  logic                      s_last,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_addr,
  input  logic [1:0]                cfg_sel,
  input  logic [FEAT_W-1:0]         cfg_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*NUM_FEATURES-1:0] m_data,
  output logic [7:0]                err_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      s_ready_q, s_ready_d;
  logic                      m_valid_q, m_valid_d;
  logic [2*NUM_FEATURES-1:0] m_data_q, m_data_d;
  logic [7:0]                err_q, err_d;

  logic [FEAT_W-1:0] thr0_q [NUM_FEATURES];
  logic [FEAT_W-1:0] thr1_q [NUM_FEATURES];
  logic [FEAT_W-1:0] thr2_q [NUM_FEATURES];
  logic [FEAT_W-1:0] thr0_d [NUM_FEATURES];
  logic [FEAT_W-1:0] thr1_d [NUM_FEATURES];
  logic [FEAT_W-1:0] thr2_d [NUM_FEATURES];

  logic       beat;
  logic       err_inc;
  logic       cfg_hit;
  logic       ge0, ge1, ge2;
  logic [1:0] q_code;

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err_cnt = err_q;

  assign beat    = s_valid && s_ready_q;
  assign cfg_hit = cfg_we && (int'(cfg_addr) < NUM_FEATURES);

  // The beat sees the thresholds as they were before any same-cycle write.
  always_comb begin
    ge0    = (s_data >= thr0_q[idx_q]);
    ge1    = (s_data >= thr1_q[idx_q]);
    ge2    = (s_data >= thr2_q[idx_q]);
    q_code = {1'b0, ge0} + {1'b0, ge1} + {1'b0, ge2};
  end

  always_comb begin
    thr0_d = thr0_q;
    thr1_d = thr1_q;
    thr2_d = thr2_q;
    if (cfg_hit) begin
      case (cfg_sel)
        2'd0:    thr0_d[cfg_addr] = cfg_data;
        2'd1:    thr1_d[cfg_addr] = cfg_data;
        2'd2:    thr2_d[cfg_addr] = cfg_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    m_data_d = m_data_q;
    err_d    = err_q;
    err_inc  = 1'b0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (beat) begin
          for (int i = 0; i < NUM_FEATURES; i++) begin
            if (idx_q == IDX_W'(i)) m_data_d[2*i +: 2] = q_code;
          end
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_last) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_DRAIN;
              err_inc = 1'b1;
            end
          end else if (s_last) begin
            idx_d   = '0;
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_HOLD: begin
        if (m_valid_q && m_ready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (beat && s_last) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    // Handshake flags are registered from the next state so they line up with it.
    s_ready_d = (state_d != ST_HOLD);
    m_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= '0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
        thr0_q[i] <= T0_INIT;
        thr1_q[i] <= T1_INIT;
        thr2_q[i] <= T2_INIT;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
      thr0_q    <= thr0_d;
      thr1_q    <= thr1_d;
      thr2_q    <= thr2_d;
    end
  end

endmodule
